// File: rtl/regfile_pkg.sv
// Shared constants for the multiport register file: default widths, the zero
// register/data constants and the named read-port indices.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam logic [0:DEF_DATA_W-1] DATA_ZERO = '0;

    // Port 0 drives the system bus, port 1 the ALU; higher ports are spares.
    localparam int RD_SBUS = 0;
    localparam int RD_ALU  = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: a reserve sets, a write clears, and the reserve
// wins when both hit the same entry. Entry 0 is never pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_sel,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_sel,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] w_pending;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
        if (gi == REG_ZERO) begin : g_zero
            assign w_pending[gi] = 1'b0;
        end else begin : g_bit
            logic r_pend;
            always_ff @(posedge clk) begin
                if (rst)
                    r_pend <= 1'b0;
                else if (rsv_en && rsv_sel == ADDR_W'(gi))
                    r_pend <= 1'b1;
                else if (wr_en && wr_sel == ADDR_W'(gi))
                    r_pend <= 1'b0;
            end
            assign w_pending[gi] = r_pend;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_busy
        assign rd_busy[gi] = w_pending[rd_sel[gi*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_multiport.sv
// Clocked register file: one synchronous write port, NUM_RD combinational read
// ports, hardwired-zero entry 0 and a pending-bit scoreboard. Data vectors are
// MSB-first ([0] is the MSB). Optional same-cycle write-to-read forwarding is
// enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        select_write,
    input  logic [0:DATA_W-1]        systembus_in,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [0:NUM_RD*DATA_W-1] rd_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_sel,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [0:DATA_W-1] w_mem [DEPTH];
    logic [NUM_RD-1:0] w_busy_raw;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        if (gi == REG_ZERO) begin : g_zero
            assign w_mem[gi] = DATA_W'(DATA_ZERO);
        end else begin : g_reg
            logic [0:DATA_W-1] r_entry;
            always_ff @(posedge clk) begin
                if (rst)
                    r_entry <= '0;
                else if (wr_en && select_write == ADDR_W'(gi))
                    r_entry <= systembus_in;
            end
            assign w_mem[gi] = r_entry;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (select_write),
        .rsv_en  (rsv_en),
        .rsv_sel (rsv_sel),
        .rd_sel  (rd_sel),
        .rd_busy (w_busy_raw)
    );

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
        logic [ADDR_W-1:0] w_sel;
        assign w_sel = rd_sel[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight write unless reset is dropping it this cycle.
        logic w_hit;
        assign w_hit = !rst && wr_en && (select_write == w_sel)
                       && (w_sel != ADDR_W'(REG_ZERO));
        assign rd_data[gi*DATA_W +: DATA_W] = w_hit ? systembus_in : w_mem[w_sel];
        assign rd_busy[gi] = w_hit ? (rsv_en && rsv_sel == select_write)
                                   : w_busy_raw[gi];
`else
        assign rd_data[gi*DATA_W +: DATA_W] = w_mem[w_sel];
        assign rd_busy[gi] = w_busy_raw[gi];
`endif
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: directed vector table, random
// traffic against an array-based reference model, and a 16x8x3-port sweep.
`timescale 1ns/1ps
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration instance
    logic        rst, wr_en, rsv_en;
    logic [4:0]  select_write, rsv_sel;
    logic [0:31] systembus_in;
    logic [9:0]  rd_sel;
    logic [0:63] rd_data;
    logic [1:0]  rd_busy;

    regfile_multiport dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .select_write (select_write),
        .systembus_in (systembus_in),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .rsv_en       (rsv_en),
        .rsv_sel      (rsv_sel),
        .rd_busy      (rd_busy)
    );

    // Narrow three-port instance
    logic        rst3, wr_en3, rsv_en3;
    logic [2:0]  wsel3, rsv_sel3;
    logic [0:15] wdata3;
    logic [8:0]  rd_sel3;
    logic [0:47] rd_data3;
    logic [2:0]  rd_busy3;

    regfile_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) dut3 (
        .clk          (clk),
        .rst          (rst3),
        .wr_en        (wr_en3),
        .select_write (wsel3),
        .systembus_in (wdata3),
        .rd_sel       (rd_sel3),
        .rd_data      (rd_data3),
        .rsv_en       (rsv_en3),
        .rsv_sel      (rsv_sel3),
        .rd_busy      (rd_busy3)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: plain arrays of register contents and pending flags
    logic [31:0] m_mem  [32];
    bit          m_pend [32];

    function automatic logic [31:0] mdl_data(input logic [4:0] s);
        if (s == 0) return 32'h0;
        if (BYP && wr_en && !rst && select_write == s) return systembus_in;
        return m_mem[s];
    endfunction

    function automatic logic mdl_busy(input logic [4:0] s);
        if (s == 0) return 1'b0;
        if (BYP && wr_en && !rst && select_write == s) return rsv_en && (rsv_sel == s);
        return m_pend[s];
    endfunction

    task automatic mdl_commit();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (wr_en && select_write != 0) m_mem[select_write] = systembus_in;
            if (wr_en) m_pend[select_write] = 1'b0;
            if (rsv_en && rsv_sel != 0) m_pend[rsv_sel] = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] ws,
                         input logic [31:0] wd, input logic re, input logic [4:0] rs,
                         input logic [4:0] s0, input logic [4:0] s1);
        rst = r; wr_en = we; select_write = ws; systembus_in = wd;
        rsv_en = re; rsv_sel = rs; rd_sel = {s1, s0};
    endtask

    task automatic finish_cycle();
        mdl_commit();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        r, we;
        logic [4:0]  ws;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  rs, s0, s1;
        logic [31:0] e0, e1;
        logic        b0, b1;
    } vec_t;

    vec_t tv[$];

    task automatic add(input string n, input logic r, input logic we, input logic [4:0] ws,
                       input logic [31:0] wd, input logic re, input logic [4:0] rs,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic b0, input logic b1);
        vec_t v;
        v.name = n; v.r = r; v.we = we; v.ws = ws; v.wd = wd; v.re = re; v.rs = rs;
        v.s0 = s0; v.s1 = s1; v.e0 = e0; v.e1 = e1; v.b0 = b0; v.b1 = b1;
        tv.push_back(v);
    endtask

    function automatic logic [15:0] sweep_val(input int e);
        return (e == 0) ? 16'h0 : 16'(16'h1111 * e);
    endfunction

    initial begin
        //  name          rst we ws  wdata          re rs  s0  s1  exp0           exp1           b0 b1
        add("reset_r0",     0, 0, 0, 32'h0,          0, 0,  0,  0, 32'h0,         32'h0,          0, 0);
        add("reset_r7_31",  0, 0, 0, 32'h0,          0, 0,  7, 31, 32'h0,         32'h0,          0, 0);
        add("wr7",          0, 1, 7, 32'hDEADBEEF,   0, 0,  7,  7, BYP ? 32'hDEADBEEF : 32'h0,
                                                                   BYP ? 32'hDEADBEEF : 32'h0,  0, 0);
        add("rd7",          0, 0, 0, 32'h0,          0, 0,  7,  7, 32'hDEADBEEF,  32'hDEADBEEF,   0, 0);
        add("wr0",          0, 1, 0, 32'hFFFFFFFF,   0, 0,  0,  7, 32'h0,         32'hDEADBEEF,   0, 0);
        add("rd0",          0, 0, 0, 32'h0,          0, 0,  0,  0, 32'h0,         32'h0,          0, 0);
        add("rsv12",        0, 0, 0, 32'h0,          1, 12, 12, 12, 32'h0,        32'h0,          0, 0);
        add("busy12",       0, 0, 0, 32'h0,          0, 0, 12, 12, 32'h0,         32'h0,          1, 1);
        add("wr12",         0, 1, 12, 32'h55,        0, 0, 12, 12, BYP ? 32'h55 : 32'h0,
                                                                   BYP ? 32'h55 : 32'h0, !BYP, !BYP);
        add("rd12",         0, 0, 0, 32'h0,          0, 0, 12, 12, 32'h55,        32'h55,         0, 0);
        add("rsvwr12",      0, 1, 12, 32'h66,        1, 12, 12, 12, BYP ? 32'h66 : 32'h55,
                                                                   BYP ? 32'h66 : 32'h55,  BYP, BYP);
        add("rd12_busy",    0, 0, 0, 32'h0,          0, 0, 12, 12, 32'h66,        32'h66,         1, 1);
        add("wr3_byp",      0, 1, 3, 32'h12345678,   0, 0,  7,  3, 32'hDEADBEEF,
                                                                   BYP ? 32'h12345678 : 32'h0,  0, 0);
        add("rd3",          0, 0, 0, 32'h0,          0, 0,  3,  3, 32'h12345678,  32'h12345678,   0, 0);
        add("wr5_rsv5",     0, 1, 5, 32'hA5A5A5A5,   1, 5,  5,  5, BYP ? 32'hA5A5A5A5 : 32'h0,
                                                                   BYP ? 32'hA5A5A5A5 : 32'h0,  BYP, BYP);
        add("rd5_busy",     0, 0, 0, 32'h0,          0, 0,  5,  5, 32'hA5A5A5A5,  32'hA5A5A5A5,   1, 1);
        add("rst_wr5",      1, 1, 5, 32'h11111111,   1, 5,  5,  5, 32'hA5A5A5A5,  32'hA5A5A5A5,   1, 1);
        add("rd5_after_rst",0, 0, 0, 32'h0,          0, 0,  5,  5, 32'h0,         32'h0,          0, 0);
        add("rd7_12_rst",   0, 0, 0, 32'h0,          0, 0,  7, 12, 32'h0,         32'h0,          0, 0);

        // Reset both instances together
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        rst3 = 1'b1; wr_en3 = 1'b0; wsel3 = '0; wdata3 = '0; rsv_en3 = 1'b0; rsv_sel3 = '0; rd_sel3 = '0;
        @(posedge clk); #1;
        finish_cycle();
        rst = 1'b0; rst3 = 1'b0;

        // Sweep on the narrow instance: fill 1..7, then read round-robin
        for (int i = 1; i < 8; i++) begin
            wr_en3 = 1'b1; wsel3 = 3'(i); wdata3 = sweep_val(i);
            @(posedge clk); #1;
        end
        wr_en3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int p = 0; p < 3; p++) rd_sel3[p*3 +: 3] = 3'((c + p) % 8);
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("sweep_c%0d_p%0d", c, p), 64'(rd_data3[p*16 +: 16]),
                    64'(sweep_val((c + p) % 8)));
            end
            chk($sformatf("sweep_busy_c%0d", c), 64'(rd_busy3), 64'h0);
            $display("sweep c=%0d sel=%0d/%0d/%0d data=%h/%h/%h", c, rd_sel3[2:0], rd_sel3[5:3],
                     rd_sel3[8:6], rd_data3[0:15], rd_data3[16:31], rd_data3[32:47]);
            @(posedge clk); #1;
        end

        // Directed vector table on the default instance
        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].we, tv[i].ws, tv[i].wd, tv[i].re, tv[i].rs, tv[i].s0, tv[i].s1);
            @(negedge clk);
            chk({tv[i].name, "_d0"}, 64'(rd_data[0:31]),  64'(tv[i].e0));
            chk({tv[i].name, "_d1"}, 64'(rd_data[32:63]), 64'(tv[i].e1));
            chk({tv[i].name, "_b0"}, 64'(rd_busy[0]),     64'(tv[i].b0));
            chk({tv[i].name, "_b1"}, 64'(rd_busy[1]),     64'(tv[i].b1));
            $display("vec %-14s rd=%h/%h busy=%b", tv[i].name, rd_data[0:31], rd_data[32:63], rd_busy);
            finish_cycle();
        end

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ws, rs, s0, s1;
            ws = 5'($urandom_range(0, 9));
            rs = 5'($urandom_range(0, 9));
            s0 = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 9));
            s1 = ($urandom_range(0, 3) == 0) ? s0 : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 49) == 0), 1'($urandom), ws, $urandom,
                  ($urandom_range(0, 2) == 0), rs, s0, s1);
            @(negedge clk);
            chk($sformatf("rnd%0d_d0", n), 64'(rd_data[0:31]),  64'(mdl_data(s0)));
            chk($sformatf("rnd%0d_d1", n), 64'(rd_data[32:63]), 64'(mdl_data(s1)));
            chk($sformatf("rnd%0d_b0", n), 64'(rd_busy[0]),     64'(mdl_busy(s0)));
            chk($sformatf("rnd%0d_b1", n), 64'(rd_busy[1]),     64'(mdl_busy(s1)));
            $display("rnd %0d rst=%b we=%b ws=%0d rsv=%b/%0d sel=%0d/%0d rd=%h/%h busy=%b",
                     n, rst, wr_en, ws, rsv_en, rs, s0, s1, rd_data[0:31], rd_data[32:63], rd_busy);
            finish_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
